// File: rtl/noc_mmr_tx_if.sv
// Purpose: bundles the MMR write bus, the NoC transmit handshake and the status word of noc_mmr_tx.
// Latency: none (wires only).
// Backpressure: noc_tx_ready from the router holds noc_tx_valid/noc_tx_flit stable until accepted.
// Ports: mmr_we/mmr_location/loadnoc_data (writeback -> block), noc_tx_valid/noc_tx_flit (block -> router),
//        noc_tx_ready (router -> block), mmr_status (block -> software poll path).
// Modports: master = writeback stage + router side, slave = the transmit block itself.
interface noc_mmr_tx_if;
    logic        mmr_we;
    logic [31:0] mmr_location;
    logic [31:0] loadnoc_data;
    logic        noc_tx_valid;
    logic        noc_tx_ready;
    logic [39:0] noc_tx_flit;
    logic [31:0] mmr_status;

    modport master (
        output mmr_we,
        output mmr_location,
        output loadnoc_data,
        output noc_tx_ready,
        input  noc_tx_valid,
        input  noc_tx_flit,
        input  mmr_status
    );

    modport slave (
        input  mmr_we,
        input  mmr_location,
        input  loadnoc_data,
        input  noc_tx_ready,
        output noc_tx_valid,
        output noc_tx_flit,
        output mmr_status
    );
endinterface

// File: rtl/noc_mmr_tx.sv
// Purpose: memory-mapped NoC transmitter; MMR writes queue {dest,data} in a FIFO that feeds a one-flit output register.
// Latency: TX_DATA write at edge E0 -> flit valid after E1 (two edges) when idle and enabled; 1 flit/cycle sustained.
// Backpressure: flit held stable until noc_tx_ready; pushes to a full FIFO are dropped and set sticky overflow.
// Ports: clk, reset (synchronous, active-low), bus (noc_mmr_tx_if.slave: MMR write bus, NoC tx handshake, mmr_status).
module noc_mmr_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int          DEPTH     = 4,
    parameter logic [3:0]  NODE_ID   = 4'h0
) (
    input  logic         clk,
    input  logic         reset,
    noc_mmr_tx_if.slave  bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [31:0] ADDR_DATA = BASE_ADDR;
    localparam logic [31:0] ADDR_DEST = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_CTRL = BASE_ADDR + 32'h8;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] data;
    } entry_t;

    typedef struct packed {
        logic [3:0]  dest;
        logic [3:0]  src;
        logic [31:0] data;
    } flit_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [3:0]    dest_reg;
    logic          overflow;
    logic          tx_enable;
    logic [15:0]   sent_cnt;

    logic          out_vld;
    flit_t         out_flit;

    logic          wr_data;
    logic          wr_dest;
    logic          wr_ctrl;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          handshake;

    // Full 32-bit decode; the reserved slot and everything outside the window fall through.
    assign wr_data    = bus.mmr_we && (bus.mmr_location == ADDR_DATA);
    assign wr_dest    = bus.mmr_we && (bus.mmr_location == ADDR_DEST);
    assign wr_ctrl    = bus.mmr_we && (bus.mmr_location == ADDR_CTRL);

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // Fullness is judged on pre-edge state, so a same-cycle pop never rescues a push into a full FIFO.
    assign push       = wr_data && !fifo_full;
    assign handshake  = out_vld && bus.noc_tx_ready;
    // Loading on the handshake cycle itself gives back-to-back flits without a bubble.
    assign pop        = tx_enable && !fifo_empty && (!out_vld || handshake);

    // Storage array carries no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{dest: dest_reg, data: bus.loadnoc_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dest_reg  <= 4'h0;
            overflow  <= 1'b0;
            tx_enable <= 1'b1;
            sent_cnt  <= 16'h0;
            out_vld   <= 1'b0;
            out_flit  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (wr_data && fifo_full) begin
                overflow <= 1'b1;
            end
            if (wr_dest) begin
                dest_reg <= bus.loadnoc_data[3:0];
            end
            if (wr_ctrl) begin
                tx_enable <= bus.loadnoc_data[1];
                if (bus.loadnoc_data[0]) begin
                    overflow <= 1'b0;
                end
            end

            if (handshake) begin
                sent_cnt <= sent_cnt + 16'h1;
            end

            // tx_enable only gates loads; a flit already presented stays until accepted.
            if (pop) begin
                out_vld  <= 1'b1;
                out_flit <= '{dest: mem[rd_ptr].dest, src: NODE_ID, data: mem[rd_ptr].data};
            end else if (handshake) begin
                out_vld  <= 1'b0;
            end
        end
    end

    assign bus.noc_tx_valid = out_vld;
    assign bus.noc_tx_flit  = out_flit;
    assign bus.mmr_status   = {sent_cnt, 8'(count), 3'b000, tx_enable, out_vld,
                               overflow, fifo_empty, fifo_full};
endmodule

// File: tb/tb_noc_mmr_tx.sv
// Purpose: randomized + directed bench for noc_mmr_tx with a queue-based reference model and a flit scoreboard.
// Latency: inputs change 2 time units after each rising edge; outputs are compared on the falling edge.
// Backpressure: noc_tx_ready is driven both held and randomized.
module tb_noc_mmr_tx;
    localparam logic [31:0] BASE    = 32'h0000_4000;
    localparam int          DEPTH   = 4;
    localparam logic [3:0]  NODE_ID = 4'h0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    noc_mmr_tx_if bus();

    noc_mmr_tx #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .NODE_ID(NODE_ID)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the FIFO is an unbounded queue capped at DEPTH, the output slot a single flit.
    logic [35:0] m_q[$];
    logic [39:0] exp_q[$];
    logic        m_vld   = 1'b0;
    logic [39:0] m_flit  = '0;
    logic [3:0]  m_dest  = 4'h0;
    logic        m_ovf   = 1'b0;
    logic        m_en    = 1'b1;
    logic [15:0] m_sent  = 16'h0;
    bit          m_was_full;
    bit          m_hs;

    function automatic logic [31:0] m_status();
        int n;
        n = m_q.size();
        return {m_sent, 8'(n), 3'b000, m_en, m_vld, m_ovf, (n == 0), (n == DEPTH)};
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_q.delete();
            exp_q.delete();
            m_vld  = 1'b0;
            m_flit = '0;
            m_dest = 4'h0;
            m_ovf  = 1'b0;
            m_en   = 1'b1;
            m_sent = 16'h0;
        end else begin
            m_was_full = (m_q.size() == DEPTH);
            m_hs       = m_vld && bus.noc_tx_ready;
            if (m_hs) m_sent = m_sent + 16'h1;
            if (m_en && m_q.size() != 0 && (!m_vld || m_hs)) begin
                m_flit = {m_q[0][35:32], NODE_ID, m_q[0][31:0]};
                void'(m_q.pop_front());
                m_vld = 1'b1;
            end else if (m_hs) begin
                m_vld = 1'b0;
            end
            if (bus.mmr_we) begin
                if (bus.mmr_location == BASE) begin
                    if (m_was_full) m_ovf = 1'b1;
                    else begin
                        m_q.push_back({m_dest, bus.loadnoc_data});
                        exp_q.push_back({m_dest, NODE_ID, bus.loadnoc_data});
                    end
                end else if (bus.mmr_location == BASE + 32'h4) begin
                    m_dest = bus.loadnoc_data[3:0];
                end else if (bus.mmr_location == BASE + 32'h8) begin
                    m_en = bus.loadnoc_data[1];
                    if (bus.loadnoc_data[0]) m_ovf = 1'b0;
                end
            end
        end
    end

    // Monitor: state comparison every cycle, scoreboard pop on every accepted flit.
    bit          mon_en = 1'b0;
    int          hs_total = 0;
    logic [39:0] last_flit = '0;
    logic [39:0] prev_flit = '0;
    logic [39:0] sb_e;

    always @(negedge clk) begin
        if (mon_en) begin
            check("status", {32'h0, bus.mmr_status}, {32'h0, m_status()});
            check("valid", {63'h0, bus.noc_tx_valid}, {63'h0, m_vld});
            if (m_vld) check("flit", {24'h0, bus.noc_tx_flit}, {24'h0, m_flit});
            if (reset && bus.noc_tx_valid && bus.noc_tx_ready) begin
                hs_total++;
                prev_flit = last_flit;
                last_flit = bus.noc_tx_flit;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_flit actual=%0h required=none", bus.noc_tx_flit);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_flit", {24'h0, bus.noc_tx_flit}, {24'h0, sb_e});
                end
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 of the edge that sampled the write.
    task automatic mmr_write(input logic [31:0] a, input logic [31:0] d);
        bus.mmr_we       = 1'b1;
        bus.mmr_location = a;
        bus.loadnoc_data = d;
        @(posedge clk); #2;
        bus.mmr_we       = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    int hs0;
    int r;

    initial begin
        reset            = 1'b0;
        bus.mmr_we       = 1'b0;
        bus.mmr_location = 32'h0;
        bus.loadnoc_data = 32'h0;
        bus.noc_tx_ready = 1'b0;
        cycles(2);
        reset = 1'b1;
        check("reset_status", {32'h0, bus.mmr_status}, 64'h12);
        check("reset_valid", {63'h0, bus.noc_tx_valid}, 64'h0);
        check("reset_flit", {24'h0, bus.noc_tx_flit}, 64'h0);
        mon_en = 1'b1;

        // Single send with two-edge latency.
        bus.noc_tx_ready = 1'b1;
        mmr_write(BASE + 32'h4, 32'h5);
        mmr_write(BASE, 32'hDEAD_BEEF);
        check("latency_e0_valid", {63'h0, bus.noc_tx_valid}, 64'h0);
        cycles(1);
        check("latency_e1_valid", {63'h0, bus.noc_tx_valid}, 64'h1);
        check("single_flit", {24'h0, bus.noc_tx_flit}, 64'h50_DEAD_BEEF);
        cycles(1);
        check("single_sent_cnt", {48'h0, bus.mmr_status[31:16]}, 64'h1);

        // Backpressure: 6 writes, 1 presented + 4 queued + 1 dropped.
        bus.noc_tx_ready = 1'b0;
        bus.mmr_we       = 1'b1;
        bus.mmr_location = BASE;
        for (int i = 0; i < 6; i++) begin
            bus.loadnoc_data = 32'h1000_0000 + i;
            @(posedge clk); #2;
        end
        bus.mmr_we = 1'b0;
        check("bp_full", {63'h0, bus.mmr_status[0]}, 64'h1);
        check("bp_overflow", {63'h0, bus.mmr_status[2]}, 64'h1);
        check("bp_count", {56'h0, bus.mmr_status[15:8]}, 64'h4);
        cycles(3);
        check("bp_flit_stable", {24'h0, bus.noc_tx_flit}, 64'h50_1000_0000);
        hs0 = hs_total;
        bus.noc_tx_ready = 1'b1;
        cycles(5);
        check("bp_drain_count", hs_total - hs0, 5);
        check("bp_last_word", {24'h0, last_flit}, 64'h50_1000_0004);
        check("bp_valid_after", {63'h0, bus.noc_tx_valid}, 64'h0);

        // Enable gating.
        mmr_write(BASE + 32'h8, 32'h0);
        mmr_write(BASE, 32'hA1A1_0001);
        mmr_write(BASE, 32'hA1A1_0002);
        cycles(3);
        check("gate_valid", {63'h0, bus.noc_tx_valid}, 64'h0);
        check("gate_count", {56'h0, bus.mmr_status[15:8]}, 64'h2);
        hs0 = hs_total;
        mmr_write(BASE + 32'h8, 32'h2);
        cycles(4);
        check("gate_drained", hs_total - hs0, 2);
        check("gate_count_after", {56'h0, bus.mmr_status[15:8]}, 64'h0);
        mmr_write(BASE + 32'h8, 32'h1);
        check("ctrl_clear_overflow", {63'h0, bus.mmr_status[2]}, 64'h0);
        check("ctrl_disable", {63'h0, bus.mmr_status[4]}, 64'h0);
        mmr_write(BASE + 32'h8, 32'h2);

        // Destination captured per entry.
        mmr_write(BASE + 32'h4, 32'h2);
        mmr_write(BASE, 32'hAAAA_0000);
        mmr_write(BASE + 32'h4, 32'h9);
        mmr_write(BASE, 32'hBBBB_0000);
        cycles(4);
        check("dest_first", {24'h0, prev_flit}, 64'h20_AAAA_0000);
        check("dest_second", {24'h0, last_flit}, 64'h90_BBBB_0000);

        // Streaming push every cycle with ready high: occupancy stays at or below 1.
        bus.mmr_we       = 1'b1;
        bus.mmr_location = BASE;
        for (int i = 0; i < 20; i++) begin
            bus.loadnoc_data = 32'h5000_0000 + i;
            @(posedge clk); #2;
            check("stream_count_le1", {63'h0, (bus.mmr_status[15:8] <= 8'd1)}, 64'h1);
        end
        bus.mmr_we = 1'b0;
        cycles(3);
        check("stream_no_overflow", {63'h0, bus.mmr_status[2]}, 64'h0);
        check("stream_last_word", {24'h0, last_flit}, 64'h90_5000_0013);

        // Reset while a flit is presented.
        bus.noc_tx_ready = 1'b0;
        mmr_write(BASE, 32'hCAFE_0001);
        cycles(1);
        check("pre_reset_valid", {63'h0, bus.noc_tx_valid}, 64'h1);
        reset = 1'b0;
        cycles(1);
        check("mid_reset_valid", {63'h0, bus.noc_tx_valid}, 64'h0);
        check("mid_reset_status", {32'h0, bus.mmr_status}, 64'h12);
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            bus.mmr_we = (r < 45);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: bus.mmr_location = BASE;
                5:             bus.mmr_location = BASE + 32'h4;
                6:             bus.mmr_location = BASE + 32'h8;
                7:             bus.mmr_location = BASE + 32'hC;
                default:       bus.mmr_location = $urandom;
            endcase
            bus.loadnoc_data = $urandom;
            if (bus.mmr_location == BASE + 32'h8)
                bus.loadnoc_data[1] = ($urandom_range(0, 99) < 80);
            bus.noc_tx_ready = ($urandom_range(0, 99) < 60);
            @(posedge clk); #2;
        end
        bus.mmr_we = 1'b0;

        // Drain whatever the random phase left behind.
        bus.noc_tx_ready = 1'b1;
        mmr_write(BASE + 32'h8, 32'h2);
        cycles(DEPTH + 4);
        check("final_sb_empty", exp_q.size(), 0);
        check("final_valid", {63'h0, bus.noc_tx_valid}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
